// File: rtl/ntt_core_seq.sv
// In-place, self-sequencing Cooley-Tukey NTT over one N = 2^LOG_N polynomial.
// One butterfly is issued per cycle into a 3-deep pipeline; twiddles come from an external ROM.
module ntt_core_seq #(
  parameter int              WIDTH = 30,
  parameter int              LOG_N = 12,
  parameter longint unsigned Q     = 998244353
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [LOG_N-1:0] load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LOG_N-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] tw_addr,
  input  logic [WIDTH-1:0] tw_data
);

  localparam int                 N    = 1 << LOG_N;
  localparam int                 HALF = N / 2;
  localparam int                 LAT  = 3;
  localparam logic [2*WIDTH-1:0] QP   = (2*WIDTH)'(Q);
  localparam logic [WIDTH:0]     QS   = (WIDTH+1)'(Q);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  state_e             state_q, state_d;
  logic [3:0]         s_q, s_d;
  logic [LOG_N-1:0]   p_q, p_d;
  logic [1:0]         drain_q, drain_d;
  logic [LOG_N-1:0]   tw_q;

  logic [WIDTH-1:0]   mem [N];

  logic               v1_q, v2_q;
  logic [WIDTH-1:0]   u1_q, vv1_q, w1_q, u2_q, x2_q;
  logic [LOG_N-1:0]   j1_q, jt1_q, j2_q, jt2_q;

  logic [LOG_N-1:0]   jAddr, jtAddr, twIssue;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sumFull, diffFull;
  logic [WIDTH-1:0]   resA, resB;

  // Butterfly indices for pair p of stage s: i = p >> (LOG_N-1-s), j = 2*i*t + (p mod t).
  always_comb begin
    int unsigned tInt, iInt, jInt;
    tInt    = 32'(N) >> (s_q + 4'd1);
    iInt    = 32'(p_q) >> (LOG_N - 1 - int'(s_q));
    jInt    = ((iInt << 1) * tInt) + (32'(p_q) & (tInt - 32'd1));
    jAddr   = LOG_N'(jInt);
    jtAddr  = LOG_N'(jInt + tInt);
    twIssue = LOG_N'((32'd1 << s_q) + iInt);
  end

  assign tw_addr = (state_q == ISSUE) ? twIssue : tw_q;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      p_q     <= '0;
      drain_q <= '0;
      tw_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      drain_q <= drain_d;
      tw_q    <= tw_addr;
      v1_q    <= (state_q == ISSUE);
      v2_q    <= v1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    drain_d = drain_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          p_d     = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (p_q == LOG_N'(HALF - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          p_d = p_q + 1'b1;
        end
      end
      DRAIN: begin
        // No forwarding: the whole stage must be written back before the next stage reads.
        busy = 1'b1;
        if (drain_q == 2'(LAT - 1)) begin
          if (s_q == 4'(LOG_N - 1)) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + 4'd1;
            p_d     = '0;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prod = (2*WIDTH)'(w1_q) * (2*WIDTH)'(vv1_q);

  always_ff @(posedge clk) begin
    u1_q  <= mem[jAddr];
    vv1_q <= mem[jtAddr];
    w1_q  <= tw_data;
    j1_q  <= jAddr;
    jt1_q <= jtAddr;
    u2_q  <= u1_q;
    x2_q  <= WIDTH'(prod % QP);
    j2_q  <= j1_q;
    jt2_q <= jt1_q;
  end

  // Both operands are below Q, so one conditional correction keeps results in [0, Q-1].
  always_comb begin
    sumFull  = {1'b0, u2_q} + {1'b0, x2_q};
    diffFull = {1'b0, u2_q} + QS - {1'b0, x2_q};
    resA     = (sumFull >= QS) ? WIDTH'(sumFull - QS) : WIDTH'(sumFull);
    resB     = (u2_q >= x2_q) ? (u2_q - x2_q) : WIDTH'(diffFull);
  end

  always_ff @(posedge clk) begin
    if (v2_q) begin
      mem[j2_q]  <= resA;
      mem[jt2_q] <= resB;
    end else if (load_en && !busy) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_ntt_core_seq.sv
// Self-checking bench for ntt_core_seq: four instances of different sizes checked against
// directed expectations and a textbook Cooley-Tukey NTT model.
module tb_ntt_core_seq;

  localparam longint unsigned QD = 998244353;
  localparam longint unsigned QS = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loadEn  [4];
  logic [11:0] loadAddr[4];
  logic [29:0] loadData[4];
  logic [11:0] rdAddr  [4];
  logic [29:0] rdData  [4];
  logic        start   [4];
  logic        busy    [4];
  logic        done    [4];
  logic [11:0] twAddr  [4];
  logic [29:0] twData  [4];

  logic [1:0]  twA0;
  logic [0:0]  twA1;
  logic [11:0] twA2;
  logic [4:0]  twA3;

  logic [29:0]     romTab[4][4096];
  longint unsigned mdl[4096];
  logic [11:0]     twLog[$];

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  assign twAddr[0] = {10'd0, twA0};
  assign twAddr[1] = {11'd0, twA1};
  assign twAddr[2] = twA2;
  assign twAddr[3] = {7'd0, twA3};

  for (genvar g = 0; g < 4; g++) begin : gRom
    assign twData[g] = romTab[g][twAddr[g]];
  end

  ntt_core_seq #(.WIDTH(30), .LOG_N(2), .Q(QS)) dutA (
    .clk(clk), .rst_n(rst_n), .load_en(loadEn[0]), .load_addr(loadAddr[0][1:0]),
    .load_data(loadData[0]), .rd_addr(rdAddr[0][1:0]), .rd_data(rdData[0]),
    .start(start[0]), .busy(busy[0]), .done(done[0]), .tw_addr(twA0), .tw_data(twData[0]));

  ntt_core_seq #(.WIDTH(30), .LOG_N(1), .Q(QS)) dutB (
    .clk(clk), .rst_n(rst_n), .load_en(loadEn[1]), .load_addr(loadAddr[1][0:0]),
    .load_data(loadData[1]), .rd_addr(rdAddr[1][0:0]), .rd_data(rdData[1]),
    .start(start[1]), .busy(busy[1]), .done(done[1]), .tw_addr(twA1), .tw_data(twData[1]));

  ntt_core_seq dutC (
    .clk(clk), .rst_n(rst_n), .load_en(loadEn[2]), .load_addr(loadAddr[2]),
    .load_data(loadData[2]), .rd_addr(rdAddr[2]), .rd_data(rdData[2]),
    .start(start[2]), .busy(busy[2]), .done(done[2]), .tw_addr(twA2), .tw_data(twData[2]));

  ntt_core_seq #(.WIDTH(30), .LOG_N(5), .Q(QD)) dutD (
    .clk(clk), .rst_n(rst_n), .load_en(loadEn[3]), .load_addr(loadAddr[3][4:0]),
    .load_data(loadData[3]), .rd_addr(rdAddr[3][4:0]), .rd_data(rdData[3]),
    .start(start[3]), .busy(busy[3]), .done(done[3]), .tw_addr(twA3), .tw_data(twData[3]));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
  endtask

  // Textbook in-place CT-NTT with twiddle ROM[m+i], applied to mdl.
  task automatic modelNtt(input int k, input int logN, input longint unsigned q);
    int n = 1 << logN;
    for (int s = 0; s < logN; s++) begin
      int m = 1 << s;
      int t = n >> (s + 1);
      for (int i = 0; i < m; i++) begin
        for (int kk = 0; kk < t; kk++) begin
          int j = 2 * i * t + kk;
          longint unsigned u = mdl[j];
          longint unsigned x = (longint'(romTab[k][m + i]) * mdl[j + t]) % q;
          mdl[j]     = (u + x) % q;
          mdl[j + t] = (u + q - x) % q;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      loadEn[k]   = 1'b1;
      loadAddr[k] = 12'(i);
      loadData[k] = 30'(mdl[i]);
    end
    @(negedge clk);
    loadEn[k] = 1'b0;
  endtask

  task automatic readAll(input int k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rdAddr[k] = 12'(i);
      #1;
      checkOutput($sformatf("%s_rd%0d", tag, i), 64'(rdData[k]), 64'(mdl[i]));
    end
  endtask

  task automatic runTransform(input int k, input int bound, input bit disturb, input bit withLoad,
                              input logic [29:0] ldVal, output int busyCnt, output bit doneOk);
    @(negedge clk);
    start[k] = 1'b1;
    if (withLoad) begin
      loadEn[k]   = 1'b1;
      loadAddr[k] = 12'd0;
      loadData[k] = ldVal;
    end
    @(negedge clk);
    start[k]  = 1'b0;
    loadEn[k] = 1'b0;
    busyCnt   = 0;
    doneOk    = 1'b0;
    twLog.delete();
    for (int c = 0; c < bound; c++) begin
      if (done[k]) begin
        doneOk = !busy[k];
        break;
      end
      if (busy[k]) begin
        busyCnt++;
        twLog.push_back(twAddr[k]);
      end
      if (disturb && c == 3) begin
        start[k]    = 1'b1;
        loadEn[k]   = 1'b1;
        loadAddr[k] = 12'd0;
        loadData[k] = 30'd9;
      end else if (disturb && c == 4) begin
        start[k]  = 1'b0;
        loadEn[k] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic finishRun(input int k, input string tag, input int busyCnt, input bit doneOk,
                           input int expBusy);
    checkOutput({tag, "_busyCycles"}, 64'(busyCnt), 64'(expBusy));
    checkOutput({tag, "_doneNotBusy"}, 64'(doneOk), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_donePulseOnce"}, 64'(done[k]), 64'd0);
  endtask

  task automatic setSmall(input longint unsigned a0, a1, a2, a3);
    mdl[0] = a0; mdl[1] = a1; mdl[2] = a2; mdl[3] = a3;
  endtask

  initial begin
    int  bc;
    bit  dok;
    int  twExp[10] = '{1, 1, 1, 1, 1, 2, 3, 3, 3, 3};
    int  doneSeen;

    for (int k = 0; k < 4; k++) begin
      loadEn[k] = 1'b0; loadAddr[k] = '0; loadData[k] = '0;
      rdAddr[k] = '0;   start[k] = 1'b0;
      for (int a = 0; a < 4096; a++) romTab[k][a] = '0;
    end
    for (int a = 0; a < 4; a++) romTab[0][a] = 30'd1;
    for (int a = 0; a < 2; a++) romTab[1][a] = 30'd16;
    for (int a = 0; a < 4096; a++) romTab[2][a] = 30'((longint'(a) * 12345 + 7) % QD);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("reset_busy%0d", k), 64'(busy[k]), 64'd0);
      checkOutput($sformatf("reset_done%0d", k), 64'(done[k]), 64'd0);
      checkOutput($sformatf("reset_twAddr%0d", k), 64'(twAddr[k]), 64'd0);
    end
    rst_n = 1'b1;

    $display("[TB] basic 4-point transform");
    setSmall(1, 2, 3, 4);
    applyStimulus(0, 4);
    runTransform(0, 100, 1'b0, 1'b0, '0, bc, dok);
    checkOutput("t1_twLogSize", 64'(twLog.size()), 64'd10);
    for (int i = 0; i < 10 && i < twLog.size(); i++)
      checkOutput($sformatf("t1_twSeq%0d", i), 64'(twLog[i]), 64'(twExp[i]));
    finishRun(0, "t1", bc, dok, 10);
    setSmall(10, 15, 13, 0);
    readAll(0, 4, "t1");

    $display("[TB] 2-point wrap-around");
    mdl[0] = 16; mdl[1] = 16;
    applyStimulus(1, 2);
    runTransform(1, 100, 1'b0, 1'b0, '0, bc, dok);
    finishRun(1, "t2", bc, dok, 4);
    mdl[0] = 0; mdl[1] = 15;
    readAll(1, 2, "t2");

    $display("[TB] reset mid-run");
    setSmall(1, 2, 3, 4);
    applyStimulus(0, 4);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_busyAtReset", 64'(busy[0]), 64'd0);
    checkOutput("t4_doneAtReset", 64'(done[0]), 64'd0);
    doneSeen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done[0] || busy[0]) doneSeen++;
      @(negedge clk);
    end
    checkOutput("t4_noDoneAfterAbort", 64'(doneSeen), 64'd0);
    applyStimulus(0, 4);
    runTransform(0, 100, 1'b0, 1'b0, '0, bc, dok);
    finishRun(0, "t4", bc, dok, 10);
    setSmall(10, 15, 13, 0);
    readAll(0, 4, "t4");

    $display("[TB] protocol: start/load while busy, then start with load");
    setSmall(1, 2, 3, 4);
    applyStimulus(0, 4);
    runTransform(0, 100, 1'b1, 1'b0, '0, bc, dok);
    finishRun(0, "t5a", bc, dok, 10);
    setSmall(10, 15, 13, 0);
    readAll(0, 4, "t5a");
    setSmall(7, 2, 3, 4);
    applyStimulus(0, 4);
    mdl[0] = 5;
    modelNtt(0, 2, QS);
    runTransform(0, 100, 1'b0, 1'b1, 30'd5, bc, dok);
    finishRun(0, "t5b", bc, dok, 10);
    readAll(0, 4, "t5b");

    $display("[TB] default-size impulse");
    for (int i = 0; i < 4096; i++) mdl[i] = (i == 0) ? 1 : 0;
    applyStimulus(2, 4096);
    runTransform(2, 30000, 1'b0, 1'b0, '0, bc, dok);
    finishRun(2, "t3", bc, dok, 24612);
    for (int i = 0; i < 4096; i++) mdl[i] = 1;
    readAll(2, 4096, "t3");

    $display("[TB] randomised 32-point runs");
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 32; a++) romTab[3][a] = 30'($urandom % QD);
      for (int i = 0; i < 32; i++) mdl[i] = $urandom % QD;
      applyStimulus(3, 32);
      modelNtt(3, 5, QD);
      runTransform(3, 500, 1'b0, 1'b0, '0, bc, dok);
      finishRun(3, $sformatf("t6r%0d", r), bc, dok, 95);
      readAll(3, 32, $sformatf("t6r%0d", r));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
